// File: rtl/cpu_ctrl.sv
// Multicycle controller: instruction register, 16-bit instruction decode, and
// Moore sequencing of register file, ALU, status and memory handshake.
module cpu_ctrl #(
  parameter int          DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [15:0]       in,
  input  logic              mem_ack,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic              write,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic              load_addr,
  output logic [1:0]        mem_cmd,
  output logic              w,
  output logic              halted,
  output logic              err
);

  typedef enum logic [3:0] {
    S_WAIT, S_DECODE, S_IMM_WR, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG,
    S_ADDR, S_ADDR_LD, S_MEM_RD, S_LD_WR, S_MEM_WR, S_HALT
  } state_t;

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  state_t        state, state_nx;
  logic [15:0]   ir;
  logic [CW-1:0] cnt;

  logic [4:0] opc5;
  logic [2:0] rn, rd, rm;
  logic is_movi, is_movr, is_alu, is_cmp, is_mvn, is_ldr, is_str, is_halt;
  logic in_mem, at_limit, timeout, illegal;

  assign opc5    = ir[15:11];
  assign rn      = ir[10:8];
  assign rd      = ir[7:5];
  assign rm      = ir[2:0];
  assign is_movi = (opc5 == 5'b11010);
  assign is_movr = (opc5 == 5'b11000);
  assign is_alu  = (ir[15:13] == 3'b101);
  assign is_cmp  = (opc5 == 5'b10101);
  assign is_mvn  = (opc5 == 5'b10111);
  assign is_ldr  = (opc5 == 5'b01100);
  assign is_str  = (opc5 == 5'b10000);
  assign is_halt = (opc5 == 5'b11100);
  assign illegal = !(is_movi || is_movr || is_alu || is_ldr || is_str || is_halt);

  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign shift  = ir[4:3];

  // cnt holds the number of ack-less cycles already spent in the memory state
  assign in_mem   = (state == S_MEM_RD) || (state == S_MEM_WR);
  assign at_limit = (MAX_WAIT != 0) &&
                    ({{(32-CW){1'b0}}, cnt} == 32'(MAX_WAIT - 1));
  assign timeout  = in_mem && !mem_ack && at_limit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_WAIT;
      ir    <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_WAIT && load)
        ir <= in;
      if (in_mem)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      if ((state == S_DECODE && illegal) || timeout)
        err <= 1'b1;
      else if (state == S_WAIT && s)
        err <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_WAIT:      if (s) state_nx = S_DECODE;
      S_DECODE: begin
        if (is_movi)                      state_nx = S_IMM_WR;
        else if (is_movr || is_mvn)       state_nx = S_GET_B;
        else if (is_alu || is_ldr || is_str) state_nx = S_GET_A;
        else if (is_halt)                 state_nx = S_HALT;
        else                              state_nx = S_WAIT;
      end
      S_GET_A:     state_nx = (is_ldr || is_str) ? S_ADDR : S_GET_B;
      S_GET_B:     state_nx = is_str ? S_MEM_WR : S_EXEC;
      S_EXEC:      state_nx = is_cmp ? S_WAIT : S_WRITE_REG;
      S_ADDR:      state_nx = S_ADDR_LD;
      S_ADDR_LD:   state_nx = is_ldr ? S_MEM_RD : S_GET_B;
      S_MEM_RD: begin
        if (mem_ack)      state_nx = S_LD_WR;
        else if (timeout) state_nx = S_WAIT;
      end
      S_MEM_WR:    if (mem_ack || timeout) state_nx = S_WAIT;
      S_HALT:      state_nx = S_HALT;
      default:     state_nx = S_WAIT;
    endcase
  end

  always_comb begin
    readnum   = 3'b000;
    writenum  = 3'b000;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    write     = 1'b0;
    ALUop     = ir[12:11];
    load_addr = 1'b0;
    mem_cmd   = 2'b00;
    w         = 1'b0;
    halted    = 1'b0;
    unique case (state)
      S_WAIT:      w = 1'b1;
      S_IMM_WR: begin
        writenum = rn;
        vsel     = 2'b01;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = is_str ? rd : rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        loadc = 1'b1;
        asel  = is_movr || is_mvn;
        loads = is_cmp;
      end
      S_WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
      end
      // effective address is always A + sximm5, independent of the op bits
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
        ALUop = 2'b00;
      end
      S_ADDR_LD:   load_addr = 1'b1;
      S_MEM_RD:    mem_cmd = 2'b01;
      S_LD_WR: begin
        writenum = rd;
        vsel     = 2'b10;
        write    = 1'b1;
      end
      S_MEM_WR:    mem_cmd = 2'b10;
      S_HALT:      halted = 1'b1;
      default:     w = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: per-instruction expected traces from a
// behavioural model, compared by a monitor each time w returns high.
module tb_cpu_ctrl;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0, reset = 1'b0, s = 1'b0, load = 1'b0, mem_ack = 1'b0;
  logic [15:0] in = 16'h0;
  logic [2:0] readnum, writenum;
  logic loada, loadb, loadc, loads, asel, bsel, write, load_addr, w, halted, err;
  logic [1:0] vsel, ALUop, shift, mem_cmd;
  logic [DATA_W-1:0] sximm5, sximm8;

  cpu_ctrl #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in), .mem_ack(mem_ack),
    .readnum(readnum), .writenum(writenum), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel),
    .write(write), .ALUop(ALUop), .shift(shift), .sximm5(sximm5),
    .sximm8(sximm8), .load_addr(load_addr), .mem_cmd(mem_cmd), .w(w),
    .halted(halted), .err(err));

  always #5 clk = ~clk;

  typedef struct {
    int span, nwrite, wnum, wvsel, wimm, ra, rb, idx_a, idx_b, idx_w;
    int nloadc, nloads, nasel, nbsel, off, addr_aluop, exec_aluop, exec_shift;
    int nrd, nwr, nladdr, err_start, err_end;
  } rec_t;

  rec_t q[$];
  int checks = 0, failures = 0, n_done = 0;
  bit mon_en = 1'b0, garbage_en = 1'b1;
  int k_target = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic rec_t rec_init();
    rec_t r = '{default: 0};
    r.ra = -1; r.rb = -1; r.exec_aluop = -1; r.exec_shift = -1;
    return r;
  endfunction

  // Expected observable trace of one instruction, from the instruction's
  // class and the number of cycles memory takes to answer (0 = never).
  function automatic rec_t model(input logic [15:0] ir, input int k);
    rec_t e = rec_init();
    int rn = int'(ir[10:8]), rd = int'(ir[7:5]), rm = int'(ir[2:0]);
    int op = int'(ir[12:11]), sh = int'(ir[4:3]);
    bit tmo = (k < 1) || (k > MAX_WAIT);
    int kk = tmo ? MAX_WAIT : k;
    logic [4:0] oc = ir[15:11];
    casez (oc)
      5'b11010: begin
        e.span = 2; e.nwrite = 1; e.wnum = rn; e.wvsel = 1; e.idx_w = 2;
        e.wimm = int'($signed(ir[7:0]));
      end
      5'b11000, 5'b10111: begin
        e.span = 4; e.rb = rm; e.idx_b = 2; e.nloadc = 1; e.nasel = 1;
        e.exec_aluop = op; e.exec_shift = sh;
        e.nwrite = 1; e.wnum = rd; e.idx_w = 4;
      end
      5'b101??: begin
        e.ra = rn; e.idx_a = 2; e.rb = rm; e.idx_b = 3; e.nloadc = 1;
        e.exec_aluop = op; e.exec_shift = sh;
        if (op == 1) begin
          e.span = 4; e.nloads = 1;
        end else begin
          e.span = 5; e.nwrite = 1; e.wnum = rd; e.idx_w = 5;
        end
      end
      5'b01100: begin
        // DECODE, GET_A, ADDR, ADDR_LD, k x MEM_RD, then LD_WR unless timed out
        e.ra = rn; e.idx_a = 2; e.nloadc = 1; e.nbsel = 1; e.nladdr = 1;
        e.off = int'($signed(ir[4:0])); e.nrd = kk; e.err_end = tmo;
        e.span = tmo ? 4 + kk : 5 + kk;
        if (!tmo) begin
          e.nwrite = 1; e.wnum = rd; e.wvsel = 2; e.idx_w = 5 + kk;
        end
      end
      5'b10000: begin
        // DECODE, GET_A, ADDR, ADDR_LD, GET_B(Rd), k x MEM_WR
        e.ra = rn; e.idx_a = 2; e.rb = rd; e.idx_b = 5; e.nloadc = 1;
        e.nbsel = 1; e.nladdr = 1; e.off = int'($signed(ir[4:0]));
        e.nwr = kk; e.err_end = tmo; e.span = 5 + kk;
      end
      default: begin
        e.span = 1; e.err_end = 1;
      end
    endcase
    return e;
  endfunction

  task automatic cmp_rec(input rec_t e, input rec_t o, input int id);
    string p = $sformatf("i%0d.", id);
    chk({p, "span"}, o.span, e.span);          chk({p, "nwrite"}, o.nwrite, e.nwrite);
    chk({p, "wnum"}, o.wnum, e.wnum);          chk({p, "wvsel"}, o.wvsel, e.wvsel);
    chk({p, "wimm"}, o.wimm, e.wimm);          chk({p, "ra"}, o.ra, e.ra);
    chk({p, "rb"}, o.rb, e.rb);                chk({p, "idx_a"}, o.idx_a, e.idx_a);
    chk({p, "idx_b"}, o.idx_b, e.idx_b);       chk({p, "idx_w"}, o.idx_w, e.idx_w);
    chk({p, "nloadc"}, o.nloadc, e.nloadc);    chk({p, "nloads"}, o.nloads, e.nloads);
    chk({p, "nasel"}, o.nasel, e.nasel);       chk({p, "nbsel"}, o.nbsel, e.nbsel);
    chk({p, "off"}, o.off, e.off);             chk({p, "addr_aluop"}, o.addr_aluop, e.addr_aluop);
    chk({p, "exec_aluop"}, o.exec_aluop, e.exec_aluop);
    chk({p, "exec_shift"}, o.exec_shift, e.exec_shift);
    chk({p, "nrd"}, o.nrd, e.nrd);             chk({p, "nwr"}, o.nwr, e.nwr);
    chk({p, "nladdr"}, o.nladdr, e.nladdr);
    chk({p, "err_start"}, o.err_start, e.err_start);
    chk({p, "err_end"}, o.err_end, e.err_end);
  endtask

  // Monitor: accumulate one w-low span, compare against the scoreboard head.
  rec_t obs;
  bit busy = 1'b0;
  always @(negedge clk) begin
    if (!mon_en || !reset) begin
      busy = 1'b0;
    end else if (!w) begin
      if (!busy) begin
        busy = 1'b1; obs = rec_init(); obs.err_start = int'(err);
      end
      obs.span++;
      if (loada) begin obs.ra = int'(readnum); obs.idx_a = obs.span; end
      if (loadb) begin obs.rb = int'(readnum); obs.idx_b = obs.span; end
      if (write) begin
        obs.nwrite++; obs.wnum = int'(writenum); obs.wvsel = int'(vsel);
        obs.idx_w = obs.span;
        if (vsel == 2'b01) obs.wimm = int'(sximm8);
      end
      if (loadc) obs.nloadc++;
      if (loads) obs.nloads++;
      if (asel) obs.nasel++;
      if (load_addr) obs.nladdr++;
      if (bsel) begin
        obs.nbsel++; obs.off = int'(sximm5); obs.addr_aluop = int'(ALUop);
      end
      if (loadc && !bsel) begin
        obs.exec_aluop = int'(ALUop); obs.exec_shift = int'(shift);
      end
      if (mem_cmd == 2'b01) obs.nrd++;
      if (mem_cmd == 2'b10) obs.nwr++;
    end else if (busy) begin
      busy = 1'b0;
      obs.err_end = int'(err);
      chk("sb_has_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) cmp_rec(q.pop_front(), obs, n_done);
      n_done++;
    end
  end

  // Memory responder: ack on the k_target-th memory cycle; noise elsewhere.
  int mcnt = 0;
  always @(negedge clk) begin
    if (mem_cmd != 2'b00) begin
      mcnt++;
      mem_ack = (k_target != 0) && (mcnt == k_target);
    end else begin
      mcnt = 0;
      mem_ack = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_w(input string nm);
    int n = 0;
    @(negedge clk);
    while (w !== 1'b1 && n < 200) begin
      if (garbage_en) begin load = 1'($urandom_range(0, 1)); in = 16'($urandom); end
      @(negedge clk);
      n++;
    end
    load = 1'b0;
    if (w !== 1'b1) chk(nm, int'(w), 1);
  endtask

  task automatic run_instr(input logic [15:0] ir, input int k, input bit split);
    wait_w("wait_w_timeout");
    k_target = k;
    if (mon_en) q.push_back(model(ir, k));
    if (split) begin
      in = ir; load = 1'b1; s = 1'b0;
      @(negedge clk);
      in = 16'($urandom); load = 1'b0; s = 1'b1;
    end else begin
      in = ir; load = 1'b1; s = 1'b1;
    end
    @(negedge clk);
    s = 1'b0; load = 1'b0;
  endtask

  function automatic logic [15:0] gen_ir();
    logic [15:0] r = 16'($urandom);
    logic [4:0] oc;
    case ($urandom_range(0, 8))
      0: oc = 5'b11010;
      1: oc = 5'b11000;
      2, 3, 4, 5: oc = {3'b101, r[12:11]};
      6: oc = 5'b01100;
      7: oc = 5'b10000;
      default: begin
        oc = 5'($urandom);
        while (oc == 5'b11010 || oc == 5'b11000 || oc[4:2] == 3'b101 ||
               oc == 5'b01100 || oc == 5'b10000 || oc == 5'b11100)
          oc = 5'($urandom);
      end
    endcase
    return {oc, r[10:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int wseen;
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_w", int'(w), 1);
    chk("rst_ctrl", int'({loada, loadb, loadc, loads, asel, bsel, write, load_addr,
                          vsel, mem_cmd, halted, err}), 0);
    chk("rst_readnum", int'(readnum), 0);
    chk("rst_writenum", int'(writenum), 0);
    chk("rst_sximm8", int'(sximm8), 0);
    chk("rst_sximm5", int'(sximm5), 0);
    reset = 1'b1;
    mon_en = 1'b1;

    run_instr(16'hD3FB, 0, 0);   // MOV R3,#-5
    run_instr(16'hA140, 0, 1);   // ADD R2,R1,R0
    run_instr(16'hA900, 0, 0);   // CMP R1,R0
    run_instr(16'h6183, 3, 0);   // LDR R4,[R1,#3], ack on 3rd cycle
    run_instr(16'h8183, 0, 0);   // STR, never acked -> timeout
    run_instr(16'hD101, 0, 0);   // s clears err
    run_instr(16'h6183, MAX_WAIT, 0);      // ack exactly at limit wins
    run_instr(16'h6183, MAX_WAIT + 1, 1);  // one too late -> timeout
    run_instr(16'h0000, 0, 0);   // illegal
    run_instr(16'hBFE1, 0, 0);   // MVN
    run_instr(16'h8A7F, 1, 0);   // STR, immediate ack, negative imm5
    for (int i = 0; i < 80; i++) begin
      int k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MAX_WAIT + 2));
      run_instr(gen_ir(), k, 1'($urandom_range(0, 1)));
    end
    wait_w("drain_timeout");
    @(negedge clk);
    chk("sb_empty", q.size(), 0);
    mon_en = 1'b0;

    // HALT absorbs s/load until reset
    run_instr(16'hE000, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("halt%0d_halted", i), int'(halted), 1);
      chk($sformatf("halt%0d_w", i), int'(w), 0);
      s = 1'($urandom_range(0, 1)); load = 1'($urandom_range(0, 1)); in = 16'hD3FB;
    end
    s = 1'b0; load = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("halt_rst_w", int'(w), 1);
    chk("halt_rst_halted", int'(halted), 0);

    // reset during EXEC of ADD; load during GET_A must not disturb IR
    garbage_en = 1'b0;
    run_instr(16'hA140, 0, 0);           // now in DECODE
    wseen = int'(write);
    @(negedge clk);                       // GET_A
    wseen += int'(write);
    chk("ga_loada", int'(loada), 1);
    in = 16'hFFFF; load = 1'b1;
    @(negedge clk);                       // GET_B
    load = 1'b0;
    wseen += int'(write);
    chk("gb_loadb", int'(loadb), 1);
    chk("gb_readnum", int'(readnum), 0);
    @(negedge clk);                       // EXEC
    wseen += int'(write);
    chk("ex_loadc", int'(loadc), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rex_w", int'(w), 1);
    chk("rex_sximm8", int'(sximm8), 0);
    repeat (3) begin
      wseen += int'(write);
      @(negedge clk);
    end
    chk("rex_no_write", wseen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
